// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose:
//   UART receive front end. The raw serial pin passes through a 2-flop
//   synchronizer. An 8N1 receiver samples each bit at its centre using a
//   fixed clocks-per-bit divider. Good bytes are written into a small FIFO
//   that the consumer drains through a valid/ready port.
//
// Parameters:
//   CLKS_PER_BIT  clocks per UART bit (even, >= 4)
//   DEPTH         FIFO entries (power of 2, >= 2)
//
// Ports:
//   clock_50_b7a  in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   uart_rx       in   asynchronous serial input, idles high
//   rx_data       out  FIFO head byte (8'h00 while empty)
//   rx_valid      out  FIFO not empty
//   rx_ready      in   consumer accepts the head byte when rx_valid is high
//   frame_err     out  one-cycle pulse: the stop bit was sampled low
//   overrun       out  one-cycle pulse: a good byte was dropped (FIFO full)
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic       clock_50_b7a,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LP_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LP_FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LP_DEPTH   = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Synchronizer flops; they reset high so that reset looks like an idle line.
  logic r_s1, r_s2;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]    r_idx,   w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_stop_good, w_stop_bad;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr, w_rd_nxt, w_wr_nxt;
  logic [AW:0]   r_count, w_count_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_valid, r_frame_err, r_overrun;
  logic          w_pop, w_push, w_full, w_drop;

  // ---- synchronizer --------------------------------------------------------
  always_ff @(posedge clock_50_b7a) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= uart_rx;
      r_s2 <= r_s1;
    end
  end

  // ---- receiver FSM --------------------------------------------------------
  always_ff @(posedge clock_50_b7a) begin
    if (reset) begin
      r_state <= S_WAIT_HIGH;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      // A line held low (break, or stuck through reset) must go high first.
      S_WAIT_HIGH: begin
        if (r_s2) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!r_s2) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      // Re-check at the start-bit centre; a high line here was only a glitch.
      S_START: begin
        if (r_cnt == LP_HALF_M1) begin
          w_cnt_nxt = '0;
          if (!r_s2) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == LP_FULL_M1) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = r_s2;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      // Leaving at the stop-bit centre lets a back-to-back start edge be seen.
      S_STOP: begin
        if (r_cnt == LP_FULL_M1) begin
          w_cnt_nxt = '0;
          if (r_s2) begin
            w_stop_good = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_WAIT_HIGH;
    endcase
  end

  // ---- FIFO ----------------------------------------------------------------
  assign w_pop  = r_valid && rx_ready;
  assign w_full = (r_count == LP_DEPTH);
  // A pop in the same cycle frees a slot for the incoming byte.
  assign w_push = w_stop_good && (!w_full || w_pop);
  assign w_drop = w_stop_good && w_full && !w_pop;

  always_comb begin
    w_rd_nxt    = w_pop  ? r_rd + 1'b1 : r_rd;
    w_wr_nxt    = w_push ? r_wr + 1'b1 : r_wr;
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
    // Registered head: when the new head slot is the one being written this
    // cycle, its data comes from the shift register rather than the array.
    if (w_count_nxt == '0)                  w_data_nxt = 8'h00;
    else if (w_push && (w_rd_nxt == r_wr))  w_data_nxt = r_shift;
    else                                    w_data_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clock_50_b7a) begin
    if (w_push) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge clock_50_b7a) begin
    if (reset) begin
      r_rd        <= '0;
      r_wr        <= '0;
      r_count     <= '0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rd        <= w_rd_nxt;
      r_wr        <= w_wr_nxt;
      r_count     <= w_count_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= (w_count_nxt != '0);
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_drop;
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo. Bytes that should be stored are
// pushed to a scoreboard queue when their frame is driven; a negedge monitor
// pops and compares on every accepted handshake and counts output pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int H     = CPB / 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       uart_rx  = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clock_50_b7a (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
    if (!reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_byte", {24'd0, rx_data}, 32'h100);
      else                   check("sb_rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame. The first posedge after the falling edge is edge 0;
  // the stop bit is sampled at edge 9*CPB + H + 2.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input bit pop_at_stop, input bit chk_rise);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(H + 2);
    if (chk_rise) check("valid_before_stop_edge", {31'd0, rx_valid}, 32'd0);
    if (pop_at_stop) rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    if (chk_rise) check("valid_at_stop_edge", {31'd0, rx_valid}, 32'd1);
    tick(CPB - H - 3);
  endtask

  task automatic drain(input string tag);
    rx_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4 && (rx_valid || exp_q.size() != 0); i++) tick(1);
    rx_ready = 1'b0;
    check({tag, "_queue_left"}, exp_q.size(), 32'd0);
    check({tag, "_valid_low"}, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int f0, o0;

    // Reset state
    reset = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    tick(4);

    // Single byte, exact latency, hold while not ready
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    tick(20);
    check("single_valid_held", {31'd0, rx_valid}, 32'd1);
    check("single_data_held", {24'd0, rx_data}, 32'hA5);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("single_valid_after_pop", {31'd0, rx_valid}, 32'd0);
    check("single_queue", exp_q.size(), 32'd0);

    // Back-to-back frames filling the FIFO, fifth overruns
    o0 = n_ovr;
    for (int k = 1; k <= 5; k++) begin
      if (k <= DEPTH) exp_q.push_back(8'(k));
      send_byte(8'(k), 1'b1, 1'b0, 1'b0);
    end
    tick(3);
    check("fill_overrun_pulses", n_ovr, o0 + 1);
    check("fill_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    tick(3);
    check("fill_valid_after3", {31'd0, rx_valid}, 32'd1);
    tick(1);
    rx_ready = 1'b0;
    check("fill_valid_after4", {31'd0, rx_valid}, 32'd0);
    check("fill_queue", exp_q.size(), 32'd0);

    // Glitch rejection
    f0 = n_ferr;
    uart_rx = 1'b0;
    tick(5);
    uart_rx = 1'b1;
    tick(40);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_frame_err", n_ferr, f0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
    drain("glitch_next");

    // Framing error followed by a long low hold
    f0 = n_ferr;
    send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    tick(40);
    uart_rx = 1'b1;
    tick(CPB);
    check("ferr_pulses", n_ferr, f0 + 1);
    check("ferr_not_stored", {31'd0, rx_valid}, 32'd0);
    exp_q.push_back(8'h66);
    send_byte(8'h66, 1'b1, 1'b0, 1'b0);
    drain("ferr_next");

    // Full FIFO with a pop on the stop edge of the next byte
    o0 = n_ovr;
    exp_q.push_back(8'h11); send_byte(8'h11, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h22); send_byte(8'h22, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h33); send_byte(8'h33, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h44); send_byte(8'h44, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h99);
    send_byte(8'h99, 1'b1, 1'b1, 1'b0);
    check("simul_no_overrun", n_ovr, o0);
    check("simul_head", {24'd0, rx_data}, 32'h22);
    drain("simul");

    // Reset in the middle of a frame, with a byte already queued
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
    f0 = n_ferr; o0 = n_ovr;
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b0;
    tick(3 * CPB);
    uart_rx = 1'b1;
    tick(H);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_data", {24'd0, rx_data}, 32'h00);
    tick(12 * CPB);
    check("midrst_valid_later", {31'd0, rx_valid}, 32'd0);
    check("midrst_no_frame_err", n_ferr, f0);
    check("midrst_no_overrun", n_ovr, o0);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1, 1'b0, 1'b0);
    drain("midrst_next");

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
